// File: rtl/array_ctrl_pkg.sv
// array_ctrl_pkg: shared FSM state type and width helper for the array sequencer
package array_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, WCLR, WLOAD, COMPUTE, DRAIN, OUT, DONE} state_t;
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/array_ctrl_if.sv
// array_ctrl_if: control/status bundle between the tile sequencer and its array/host
interface array_ctrl_if
   import array_ctrl_pkg::*;
#(parameter int HEIGHT = 4, parameter int WIDTH = 4, parameter int KMAX = 255) ();
   localparam int KW = $clog2(KMAX + 1);
   localparam int RW = cw(HEIGHT);
   logic start, abort, busy, done, wght_rd, ofm_vld;
   logic [KW-1:0] k_len;
   logic [HEIGHT-1:0] ifm_rd, en_i, clr_i, mac_done;
   logic [WIDTH-1:0] en_w, clr_w, en_o, clr_o;
   logic [RW-1:0] ofm_row;
   modport master (output start, k_len, abort,
                   input busy, done, wght_rd, ifm_rd, en_i, clr_i, mac_done,
                   en_w, clr_w, en_o, clr_o, ofm_vld, ofm_row);
   modport slave (input start, k_len, abort,
                  output busy, done, wght_rd, ifm_rd, en_i, clr_i, mac_done,
                  en_w, clr_w, en_o, clr_o, ofm_vld, ofm_row);
endinterface

// File: rtl/skew_pipe.sv
// skew_pipe: shift register with synchronous flush; stage i is the input delayed i+1 cycles
module skew_pipe #(parameter int DEPTH = 3, parameter int W = 3)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_flush,
   input  logic [W-1:0]              i_d,
   output logic [DEPTH-1:0][W-1:0]   o_q
);
   logic [DEPTH-1:0][W-1:0] r_q;
   always_ff @(posedge clk) begin
      if (rst || i_flush) r_q <= '0;
      else begin
         r_q[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
      end
   end
   assign o_q = r_q;
endmodule

// File: rtl/array_ctrl.sv
// array_ctrl: tile sequencer for the HEIGHTxWIDTH rate-coded systolic array
module array_ctrl
   import array_ctrl_pkg::*;
#(parameter int HEIGHT = 4, parameter int WIDTH = 4, parameter int MAC_CYC = 16, parameter int KMAX = 255)
(
   input logic        clk,
   input logic        rst,
   array_ctrl_if.slave bus
);
   localparam int KW = $clog2(KMAX + 1);
   localparam int SW = cw(MAC_CYC);
   localparam int CW = cw(HEIGHT + WIDTH);
   localparam int RW = cw(HEIGHT);
   localparam logic [SW-1:0] S_LAST = SW'(MAC_CYC - 1);
   localparam logic [SW-1:0] S_PRE = SW'(MAC_CYC - 2);
   localparam logic [CW-1:0] C_ROWS = CW'(HEIGHT - 1);
   localparam logic [CW-1:0] C_DRAIN = CW'(HEIGHT + WIDTH - 2);
   state_t r_state;
   logic [KW-1:0] r_k, r_vec;
   logic [SW-1:0] r_slot;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_row;
   logic r_busy, r_done, r_wclr, r_wld, r_out, r_en0, r_clr0, r_md0;
   logic [HEIGHT-2:0][2:0] w_skew;
   logic [HEIGHT-1:0][2:0] w_rows;
   logic [HEIGHT-1:0] w_en, w_clr, w_md;
   // Row-0 strobes are computed for the state being entered, so every output is a flop.
   always_ff @(posedge clk) begin
      if (rst || bus.abort) begin
         r_state <= IDLE;
         r_k <= '0;
         r_vec <= '0;
         r_slot <= '0;
         r_cnt <= '0;
         r_row <= '0;
         {r_busy, r_done, r_wclr, r_wld, r_out, r_en0, r_clr0, r_md0} <= '0;
      end else begin
         {r_done, r_wclr, r_wld, r_out, r_en0, r_clr0, r_md0} <= '0;
         r_row <= '0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_k <= bus.k_len;
               r_busy <= 1'b1;
               r_wclr <= bus.k_len != '0;
               r_done <= bus.k_len == '0;
               r_state <= (bus.k_len == '0) ? DONE : WCLR;
            end
            WCLR: begin
               r_state <= WLOAD;
               r_cnt <= '0;
               r_wld <= 1'b1;
            end
            WLOAD: if (r_cnt == C_ROWS) begin
               r_state <= COMPUTE;
               r_slot <= '0;
               r_vec <= '0;
               r_en0 <= 1'b1;
               r_clr0 <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
               r_wld <= 1'b1;
            end
            COMPUTE: if (r_slot != S_LAST) begin
               r_slot <= r_slot + 1'b1;
               r_en0 <= 1'b1;
               r_md0 <= r_slot == S_PRE;
            end else if (r_vec != r_k - 1'b1) begin
               r_vec <= r_vec + 1'b1;
               r_slot <= '0;
               r_en0 <= 1'b1;
               r_clr0 <= 1'b1;
            end else begin
               r_state <= DRAIN;
               r_cnt <= '0;
            end
            DRAIN: if (r_cnt == C_DRAIN) begin
               r_state <= OUT;
               r_cnt <= '0;
               r_out <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
            OUT: if (r_cnt == C_ROWS) begin
               r_state <= DONE;
               r_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
               r_row <= r_row + 1'b1;
               r_out <= 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
               r_busy <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   skew_pipe #(.DEPTH(HEIGHT - 1), .W(3)) u_skew (
      .clk(clk), .rst(rst), .i_flush(bus.abort),
      .i_d({r_md0, r_clr0, r_en0}), .o_q(w_skew)
   );
   assign w_rows = {w_skew, r_md0, r_clr0, r_en0};
   for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      assign w_en[h] = w_rows[h][0];
      assign w_clr[h] = w_rows[h][1];
      assign w_md[h] = w_rows[h][2];
   end
   assign bus.en_i = w_en;
   assign bus.clr_i = w_clr;
   assign bus.ifm_rd = w_clr;
   assign bus.mac_done = w_md;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.wght_rd = r_wld;
   assign bus.en_w = {WIDTH{r_wld}};
   assign bus.clr_w = {WIDTH{r_wclr}};
   assign bus.clr_o = {WIDTH{r_wclr}};
   assign bus.en_o = {WIDTH{r_out}};
   assign bus.ofm_vld = r_out;
   assign bus.ofm_row = r_row;
endmodule
